// File: rtl/vcmd_pkg.sv
// Shared types and constants for the SPI command receiver.
// No logic, no latency, no backpressure.
package vcmd_pkg;
  localparam int BYTE_W          = 8;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int CNT_W           = 3;
  localparam int STAT_ERR_BIT    = 7;
  localparam int STAT_CNT_W      = 7;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;
endpackage

// File: rtl/vcmd_spi_rx_if.sv
// Command-side bundle from the SPI receiver to the command decoder.
// Pulses are single-cycle, no backpressure: the decoder must accept every strobe.
interface vcmd_spi_rx_if;
  logic [7:0] CmdIn;
  logic       CmdRecv;
  logic       CmdRecvInt;
  logic       FrameErr;
  logic       Busy;

  modport master (output CmdIn, output CmdRecv, output CmdRecvInt, output FrameErr, output Busy);
  modport slave  (input  CmdIn, input  CmdRecv, input  CmdRecvInt, input  FrameErr, input  Busy);
endinterface

// File: rtl/vcmd_sync.sv
// N-flop level synchroniser with a selectable reset value.
// Latency N cycles; no backpressure.
module vcmd_sync #(
  parameter int   N       = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [N-1:0] chain_q, chain_d;

  always_comb begin
    chain_d = {chain_q[N-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain_q <= {N{RST_VAL}};
    else        chain_q <= chain_d;
  end

  assign q = chain_q[N-1];
endmodule

// File: rtl/vcmd_spi_rx.sv
// SPI mode-0 slave byte receiver; CmdRecv/CmdRecvInt land SYNC_STAGES+1 Clk edges after the SCK/CS_n edge is sampled.
// No backpressure. Optional MISO status byte under `VCMD_SPI_MISO_EN.
module vcmd_spi_rx
  import vcmd_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic          Clk,
  input  logic          RstN,
  input  logic          SpiSck,
  input  logic          SpiMosi,
  input  logic          SpiCsN,
  output logic          SpiMiso,
  vcmd_spi_rx_if.master cmd
);
  localparam int SETTLE = SYNC_STAGES + 2;
  localparam int SW     = $clog2(SETTLE + 1);

  logic sck_s, mosi_s, csn_s;

  vcmd_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck  (.clk(Clk), .rst_n(RstN), .d(SpiSck),  .q(sck_s));
  vcmd_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (.clk(Clk), .rst_n(RstN), .d(SpiMosi), .q(mosi_s));
  vcmd_sync #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_csn  (.clk(Clk), .rst_n(RstN), .d(SpiCsN),  .q(csn_s));

  logic sck_h_q, sck_h_d, csn_h_q, csn_h_d;
  logic sck_rise_q, sck_rise_d, cs_rise_q, cs_rise_d, cs_fall_q, cs_fall_d;
  logic mosi_q, mosi_d;
  logic [SW-1:0] settle_q, settle_d;
  logic armed_q, armed_d;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_nxt;
  logic [BYTE_W-2:0]   shift_q, shift_d;
  logic [BYTE_W-1:0]   cmd_in_q, cmd_in_d;
  logic                recv_q, recv_d, recv_int_q, recv_int_d;
  logic                ferr_q, ferr_d, busy_q, busy_d;
`ifdef VCMD_SPI_MISO_EN
  logic                sck_fall_q, sck_fall_d;
  logic [STAT_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [BYTE_W-1:0]   miso_sr_q, miso_sr_d;
`endif

  // Edge detect plus one register stage so the detected event lines up with mosi_q.
  always_comb begin
    sck_h_d    = sck_s;
    csn_h_d    = csn_s;
    sck_rise_d = sck_s & ~sck_h_q;
    cs_rise_d  = csn_s & ~csn_h_q;
    cs_fall_d  = ~csn_s & csn_h_q;
    mosi_d     = mosi_s;
`ifdef VCMD_SPI_MISO_EN
    sck_fall_d = ~sck_s & sck_h_q;
`endif
    // A CS_n already low at reset release must go high once before a frame can start.
    settle_d = settle_q;
    armed_d  = armed_q;
    if (settle_q != SW'(SETTLE)) settle_d = settle_q + SW'(1);
    else if (csn_h_q)            armed_d  = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cnt_nxt    = cnt_q;
    shift_d    = shift_q;
    cmd_in_d   = cmd_in_q;
    recv_d     = 1'b0;
    recv_int_d = 1'b0;
    ferr_d     = ferr_q;
    busy_d     = busy_q;
`ifdef VCMD_SPI_MISO_EN
    byte_cnt_d = byte_cnt_q;
    miso_sr_d  = miso_sr_q;
`endif
    case (state_q)
      IDLE: begin
        if (cs_fall_q && armed_q) begin
          state_d = SHIFT;
          cnt_d   = '0;
          ferr_d  = 1'b0;
          busy_d  = 1'b1;
`ifdef VCMD_SPI_MISO_EN
          miso_sr_d  = {ferr_q, byte_cnt_q};
          byte_cnt_d = '0;
`endif
        end
      end
      SHIFT: begin
        if (sck_rise_q) begin
          shift_d = {shift_q[BYTE_W-3:0], mosi_q};
          cnt_nxt = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(7)) begin
            cmd_in_d = {shift_q, mosi_q};
            recv_d   = 1'b1;
`ifdef VCMD_SPI_MISO_EN
            if (byte_cnt_q != {STAT_CNT_W{1'b1}}) byte_cnt_d = byte_cnt_q + STAT_CNT_W'(1);
`endif
          end
        end
`ifdef VCMD_SPI_MISO_EN
        if (sck_fall_q) miso_sr_d = {miso_sr_q[BYTE_W-2:0], 1'b0};
`endif
        cnt_d = cnt_nxt;
        // cnt_nxt already accounts for a byte completing in this same cycle.
        if (cs_rise_q) begin
          recv_int_d = 1'b1;
          busy_d     = 1'b0;
          ferr_d     = (cnt_nxt != '0);
          cnt_d      = '0;
          shift_d    = '0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      sck_h_q    <= 1'b0;
      csn_h_q    <= 1'b1;
      sck_rise_q <= 1'b0;
      cs_rise_q  <= 1'b0;
      cs_fall_q  <= 1'b0;
      mosi_q     <= 1'b0;
      settle_q   <= '0;
      armed_q    <= 1'b0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      cmd_in_q   <= '0;
      recv_q     <= 1'b0;
      recv_int_q <= 1'b0;
      ferr_q     <= 1'b0;
      busy_q     <= 1'b0;
`ifdef VCMD_SPI_MISO_EN
      sck_fall_q <= 1'b0;
      byte_cnt_q <= '0;
      miso_sr_q  <= '0;
`endif
    end else begin
      sck_h_q    <= sck_h_d;
      csn_h_q    <= csn_h_d;
      sck_rise_q <= sck_rise_d;
      cs_rise_q  <= cs_rise_d;
      cs_fall_q  <= cs_fall_d;
      mosi_q     <= mosi_d;
      settle_q   <= settle_d;
      armed_q    <= armed_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      cmd_in_q   <= cmd_in_d;
      recv_q     <= recv_d;
      recv_int_q <= recv_int_d;
      ferr_q     <= ferr_d;
      busy_q     <= busy_d;
`ifdef VCMD_SPI_MISO_EN
      sck_fall_q <= sck_fall_d;
      byte_cnt_q <= byte_cnt_d;
      miso_sr_q  <= miso_sr_d;
`endif
    end
  end

  assign cmd.CmdIn      = cmd_in_q;
  assign cmd.CmdRecv    = recv_q;
  assign cmd.CmdRecvInt = recv_int_q;
  assign cmd.FrameErr   = ferr_q;
  assign cmd.Busy       = busy_q;
`ifdef VCMD_SPI_MISO_EN
  assign SpiMiso = miso_sr_q[STAT_ERR_BIT];
`else
  assign SpiMiso = 1'b0;
`endif
endmodule
